// File: rtl/ahb_mem_slave_ctrl_if.sv
// AHB-Lite slave-side bus bundle for ahb_mem_slave_ctrl.
// The master modport is the interconnect side; the slave modport is the controller.
interface ahb_mem_slave_ctrl_if;
  logic        hsel;
  logic        hready;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic        is_signed;
  logic [31:0] hwdata;
  logic [31:0] hrdata;
  logic        hreadyout;
  logic        hresp;

  modport master (
    output hsel, hready, haddr, htrans, hwrite, hsize, is_signed, hwdata,
    input  hrdata, hreadyout, hresp
  );

  modport slave (
    input  hsel, hready, haddr, htrans, hwrite, hsize, is_signed, hwdata,
    output hrdata, hreadyout, hresp
  );
endinterface

// File: rtl/ahb_mem_slave_ctrl.sv
// Pipelined AHB-Lite slave fronting one synchronous RAM and one ROM: decode, permission and
// alignment checks, byte-lane strobes, load extension, per-region read wait states, ERROR response.
module ahb_mem_slave_ctrl #(
  parameter int unsigned DATA_W   = 32,
  parameter logic [31:0] RAM_BASE = 32'h0000_0000,
  parameter int unsigned RAM_AW   = 10,
  parameter logic [31:0] ROM_BASE = 32'h1000_0000,
  parameter int unsigned ROM_AW   = 10,
  parameter int unsigned RAM_WAIT = 0,
  parameter int unsigned ROM_WAIT = 2
) (
  input  logic                hclk,
  input  logic                hresetn,
  ahb_mem_slave_ctrl_if.slave bus,
  output logic                ram_rd_en,
  output logic                ram_wr_en,
  output logic [3:0]          ram_be,
  output logic [RAM_AW-1:0]   ram_addr,
  output logic [DATA_W-1:0]   ram_wdata,
  input  logic [DATA_W-1:0]   ram_rdata,
  output logic                rom_rd_en,
  output logic [ROM_AW-1:0]   rom_addr,
  input  logic [DATA_W-1:0]   rom_rdata,
  output logic [7:0]          err_cnt
);

  typedef enum logic [2:0] {
    StIdle, StWr, StRdReq, StRdWait, StRdData, StErr1, StErr2
  } state_e;

  localparam logic [31:0] RamMask = ~((32'd4 << RAM_AW) - 32'd1);
  localparam logic [31:0] RomMask = ~((32'd4 << ROM_AW) - 32'd1);

  state_e              state_q, state_d;
  logic [3:0]          wait_q, wait_d;
  logic [1:0]          lane_q, size_q;
  logic                sgn_q, rom_sel_q;
  logic                ram_rd_en_q, ram_wr_en_q, rom_rd_en_q;
  logic [3:0]          ram_be_q;
  logic [RAM_AW-1:0]   ram_addr_q;
  logic [ROM_AW-1:0]   rom_addr_q;
  logic [DATA_W-1:0]   hrdata_q, rd_ext;
  logic [7:0]          err_cnt_q;

  logic        ready, accept, hit_ram, hit_rom, bad_size, misalign, err_req;
  logic [31:0] ram_off, rom_off;
  logic [3:0]  be;

  function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [1:0] lane,
                                           input logic [1:0] sz, input logic sgn);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = 8'(w >> {lane, 3'b000});
    h = lane[1] ? w[31:16] : w[15:0];
    case (sz)
      2'd0:    r = {{24{sgn & b[7]}}, b};
      2'd1:    r = {{16{sgn & h[15]}}, h};
      default: r = w;
    endcase
    return r;
  endfunction

  // Transfers are only taken in cycles that end a data phase (or idle).
  assign ready  = (state_q == StIdle) || (state_q == StWr) || (state_q == StRdData) ||
                  (state_q == StErr2);
  assign accept = bus.hsel & bus.hready & bus.htrans[1] & ready;

  assign ram_off  = bus.haddr - RAM_BASE;
  assign rom_off  = bus.haddr - ROM_BASE;
  assign hit_ram  = (bus.haddr & RamMask) == RAM_BASE;
  assign hit_rom  = (bus.haddr & RomMask) == ROM_BASE;
  assign bad_size = bus.hsize > 3'd2;
  assign misalign = ((bus.hsize == 3'd1) && bus.haddr[0]) ||
                    ((bus.hsize == 3'd2) && (bus.haddr[1:0] != 2'b00));
  assign err_req  = bad_size | misalign | ~(hit_ram | hit_rom) | (hit_rom & bus.hwrite);

  always_comb begin
    be = 4'h0;
    case (bus.hsize)
      3'd0:    be = 4'b0001 << bus.haddr[1:0];
      3'd1:    be = 4'b0011 << bus.haddr[1:0];
      default: be = 4'hF;
    endcase
  end

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    unique case (state_q)
      StRdReq: begin
        wait_d  = rom_sel_q ? 4'(ROM_WAIT) : 4'(RAM_WAIT);
        state_d = (wait_d != 4'd0) ? StRdWait : StRdData;
      end
      StRdWait: begin
        if (wait_q <= 4'd1) state_d = StRdData;
        else                wait_d  = wait_q - 4'd1;
      end
      StErr1:  state_d = StErr2;
      default: state_d = state_q;
    endcase
    if (ready) begin
      if (!accept)         state_d = StIdle;
      else if (err_req)    state_d = StErr1;
      else if (bus.hwrite) state_d = StWr;
      else                 state_d = StRdReq;
    end
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q     <= StIdle;
      wait_q      <= 4'd0;
      lane_q      <= 2'd0;
      size_q      <= 2'd0;
      sgn_q       <= 1'b0;
      rom_sel_q   <= 1'b0;
      ram_rd_en_q <= 1'b0;
      ram_wr_en_q <= 1'b0;
      rom_rd_en_q <= 1'b0;
      ram_be_q    <= 4'h0;
      ram_addr_q  <= '0;
      rom_addr_q  <= '0;
      hrdata_q    <= '0;
      err_cnt_q   <= 8'd0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      ram_rd_en_q <= 1'b0;
      ram_wr_en_q <= 1'b0;
      rom_rd_en_q <= 1'b0;
      ram_be_q    <= 4'h0;
      if (accept) begin
        lane_q    <= bus.haddr[1:0];
        size_q    <= bus.hsize[1:0];
        sgn_q     <= bus.is_signed;
        rom_sel_q <= hit_rom;
        if (!err_req && hit_ram) begin
          ram_addr_q  <= ram_off[RAM_AW+1:2];
          ram_wr_en_q <= bus.hwrite;
          ram_rd_en_q <= ~bus.hwrite;
          ram_be_q    <= bus.hwrite ? be : 4'h0;
        end else if (!err_req) begin
          rom_addr_q  <= rom_off[ROM_AW+1:2];
          rom_rd_en_q <= 1'b1;
        end
      end
      if (state_q == StRdData) hrdata_q <= rd_ext;
      if ((state_q == StErr2) && (err_cnt_q != 8'hFF)) err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign rd_ext = load_ext(rom_sel_q ? rom_rdata : ram_rdata, lane_q, size_q, sgn_q);

  assign bus.hreadyout = ready;
  assign bus.hresp     = (state_q == StErr1) || (state_q == StErr2);
  assign bus.hrdata    = (state_q == StRdData) ? rd_ext : hrdata_q;
  assign ram_rd_en     = ram_rd_en_q;
  assign ram_wr_en     = ram_wr_en_q;
  assign ram_be        = ram_be_q;
  assign ram_addr      = ram_addr_q;
  // Write data is already lane-positioned on the bus and only valid in the data phase.
  assign ram_wdata     = (state_q == StWr) ? bus.hwdata : '0;
  assign rom_rd_en     = rom_rd_en_q;
  assign rom_addr      = rom_addr_q;
  assign err_cnt       = err_cnt_q;

  logic unused_bits;
  assign unused_bits = ^{bus.htrans[0], ram_off[31:RAM_AW+2], ram_off[1:0],
                         rom_off[31:ROM_AW+2], rom_off[1:0]};

endmodule

// File: tb/tb_ahb_mem_slave_ctrl.sv
// Directed bench for ahb_mem_slave_ctrl with behavioural RAM and ROM models.
module tb_ahb_mem_slave_ctrl;
  localparam logic [31:0] RamBase = 32'h0000_0000;
  localparam logic [31:0] RomBase = 32'h1000_0000;

  logic        hclk = 1'b0;
  logic        hresetn;
  logic        ram_rd_en, ram_wr_en, rom_rd_en;
  logic [3:0]  ram_be;
  logic [9:0]  ram_addr, rom_addr;
  logic [31:0] ram_wdata, ram_rdata, rom_rdata;
  logic [7:0]  err_cnt;

  logic [31:0] ram_mem [1024];
  logic [31:0] rom_p1, rom_p2;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  int unsigned r_cyc;
  logic [31:0] r_rdata, r_wdata;
  logic        r_resp_first, r_resp_last, r_strobe;
  logic [3:0]  r_be;
  logic [9:0]  r_ram_addr, r_rom_addr;
  logic        acc;

  ahb_mem_slave_ctrl_if bus ();

  ahb_mem_slave_ctrl dut (
    .hclk      (hclk),
    .hresetn   (hresetn),
    .bus       (bus.slave),
    .ram_rd_en (ram_rd_en),
    .ram_wr_en (ram_wr_en),
    .ram_be    (ram_be),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata),
    .rom_rd_en (rom_rd_en),
    .rom_addr  (rom_addr),
    .rom_rdata (rom_rdata),
    .err_cnt   (err_cnt)
  );

  always #5 hclk = ~hclk;

  always @(posedge hclk) begin
    if (ram_wr_en)
      for (int i = 0; i < 4; i++)
        if (ram_be[i]) ram_mem[ram_addr][8*i +: 8] <= ram_wdata[8*i +: 8];
    if (ram_rd_en) ram_rdata <= ram_mem[ram_addr];
  end

  // Three-stage ROM: data valid ROM_WAIT+1 = 3 cycles after the strobe.
  always @(posedge hclk) begin
    if (rom_rd_en) rom_p1 <= {16'hC0DE, 6'd0, rom_addr};
    rom_p2    <= rom_p1;
    rom_rdata <= rom_p2;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One isolated transfer, called just after a rising edge; returns just after a rising edge.
  task automatic xfer(input logic [31:0] a, input logic wr, input logic [2:0] sz,
                      input logic sg, input logic [31:0] wd);
    int unsigned n;
    bus.hsel = 1'b1; bus.htrans = 2'b10; bus.haddr = a;
    bus.hwrite = wr; bus.hsize = sz; bus.is_signed = sg;
    @(posedge hclk); #1;
    bus.hsel = 1'b0; bus.htrans = 2'b00; bus.hwdata = wd;
    r_strobe = 1'b0; r_be = 4'h0; r_wdata = 32'h0; r_ram_addr = '0; r_rom_addr = '0;
    n = 0;
    do begin
      @(negedge hclk);
      n++;
      if (n == 1) r_resp_first = bus.hresp;
      if (ram_wr_en) begin r_be = ram_be; r_wdata = ram_wdata; end
      if (ram_wr_en || ram_rd_en) r_ram_addr = ram_addr;
      if (rom_rd_en) r_rom_addr = rom_addr;
      r_strobe = r_strobe | ram_wr_en | ram_rd_en | rom_rd_en;
    end while (!bus.hreadyout && n < 40);
    r_cyc = n; r_rdata = bus.hrdata; r_resp_last = bus.hresp;
    @(posedge hclk); #1;
  endtask

  task automatic rd(input string tag, input logic [31:0] a, input logic [2:0] sz,
                    input logic sg, input logic [31:0] exp);
    xfer(a, 1'b0, sz, sg, 32'h0);
    check(tag, r_rdata, exp);
  endtask

  task automatic expect_err(input string tag, input logic [31:0] a, input logic wr,
                            input logic [2:0] sz);
    xfer(a, wr, sz, 1'b0, 32'h0);
    check({tag, " cycles"}, r_cyc, 2);
    check({tag, " resp"}, {r_resp_first, r_resp_last}, 2'b11);
    check({tag, " strobe"}, r_strobe, 0);
  endtask

  initial begin
    hresetn = 1'b0;
    bus.hsel = 1'b0; bus.hready = 1'b1; bus.haddr = 32'h0; bus.htrans = 2'b00;
    bus.hwrite = 1'b0; bus.hsize = 3'd0; bus.is_signed = 1'b0; bus.hwdata = 32'h0;
    repeat (2) @(posedge hclk);
    @(negedge hclk);
    check("rst hreadyout", bus.hreadyout, 1);
    check("rst hresp", bus.hresp, 0);
    check("rst hrdata", bus.hrdata, 0);
    check("rst strobes", {ram_rd_en, ram_wr_en, rom_rd_en, ram_be}, 0);
    check("rst addrs", {ram_addr, rom_addr}, 0);
    check("rst wdata", ram_wdata, 0);
    check("rst err_cnt", err_cnt, 0);
    @(posedge hclk); #1;
    hresetn = 1'b1;

    xfer(RamBase + 4, 1'b1, 3'd2, 1'b0, 32'hDEADBEEF);
    check("wr cycles", r_cyc, 1);
    check("wr be", r_be, 4'hF);
    check("wr addr", r_ram_addr, 1);
    check("wr wdata", r_wdata, 32'hDEADBEEF);
    xfer(RamBase + 4, 1'b0, 3'd2, 1'b0, 32'h0);
    check("rd cycles", r_cyc, 2);
    check("rd data", r_rdata, 32'hDEADBEEF);
    check("rd resp", r_resp_last, 0);
    check("rd addr", r_ram_addr, 1);
    @(negedge hclk);
    check("hrdata hold", bus.hrdata, 32'hDEADBEEF);
    @(posedge hclk); #1;

    xfer(RamBase + 8, 1'b1, 3'd2, 1'b0, 32'h80FF_7F01);
    rd("sbyte +2", RamBase + 10, 3'd0, 1'b1, 32'hFFFF_FFFF);
    rd("ubyte +2", RamBase + 10, 3'd0, 1'b0, 32'h0000_00FF);
    rd("shalf +2", RamBase + 10, 3'd1, 1'b1, 32'hFFFF_80FF);
    rd("shalf +0", RamBase + 8, 3'd1, 1'b1, 32'h0000_7F01);
    rd("sbyte +1", RamBase + 9, 3'd0, 1'b1, 32'h0000_007F);
    rd("uhalf +2", RamBase + 10, 3'd1, 1'b0, 32'h0000_80FF);

    xfer(RamBase + 2, 1'b1, 3'd1, 1'b0, 32'h1234_ABCD);
    check("half be", r_be, 4'b1100);
    xfer(RamBase + 3, 1'b1, 3'd0, 1'b0, 32'h5600_0000);
    check("byte be", r_be, 4'b1000);
    rd("lanes merged", RamBase + 2, 3'd1, 1'b0, 32'h0000_5634);

    xfer(RomBase + 8, 1'b0, 3'd2, 1'b0, 32'h0);
    check("rom cycles", r_cyc, 4);
    check("rom data", r_rdata, 32'hC0DE_0002);
    check("rom addr", r_rom_addr, 2);
    rd("rom sbyte", RomBase + 11, 3'd0, 1'b1, 32'hFFFF_FFC0);

    expect_err("rom write", RomBase, 1'b1, 3'd2);
    check("err_cnt 1", err_cnt, 1);
    expect_err("misalign word", RamBase + 2, 1'b0, 3'd2);
    expect_err("unmapped", 32'h2000_0000, 1'b0, 3'd2);
    expect_err("odd half", RamBase + 1, 1'b1, 3'd1);
    expect_err("bad size", RamBase, 1'b0, 3'd3);
    check("err_cnt 5", err_cnt, 5);
    for (int i = 0; i < 256; i++) xfer(32'h2000_0000, 1'b0, 3'd2, 1'b0, 32'h0);
    check("err_cnt sat", err_cnt, 255);

    // Pipelined write then ROM read; reset lands during the ROM wait states.
    bus.hsel = 1'b1; bus.htrans = 2'b10; bus.haddr = RamBase + 32'h20;
    bus.hwrite = 1'b1; bus.hsize = 3'd2;
    @(posedge hclk); #1;
    bus.hwdata = 32'h1122_3344; bus.haddr = RomBase + 4; bus.hwrite = 1'b0;
    @(negedge hclk);
    check("pipe wr", {bus.hreadyout, ram_wr_en}, 2'b11);
    check("pipe wdata", ram_wdata, 32'h1122_3344);
    @(posedge hclk); #1;
    bus.hsel = 1'b0; bus.htrans = 2'b00;
    @(negedge hclk);
    check("pipe rom req", {bus.hreadyout, rom_rd_en}, 2'b01);
    @(posedge hclk);
    @(negedge hclk);
    check("pipe rom wait", bus.hreadyout, 0);
    #1 hresetn = 1'b0;
    #1;
    check("arst hreadyout", bus.hreadyout, 1);
    check("arst hresp", bus.hresp, 0);
    check("arst hrdata", bus.hrdata, 0);
    check("arst err_cnt", err_cnt, 0);
    @(posedge hclk); #1;
    hresetn = 1'b1;
    acc = 1'b0;
    repeat (4) begin
      @(negedge hclk);
      acc = acc | ram_rd_en | ram_wr_en | rom_rd_en | bus.hresp | ~bus.hreadyout;
    end
    check("post-reset quiet", acc, 0);
    @(posedge hclk); #1;
    xfer(RamBase + 32'h20, 1'b0, 3'd2, 1'b0, 32'h0);
    check("post-reset cycles", r_cyc, 2);
    check("post-reset data", r_rdata, 32'h1122_3344);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
